// File: rtl/scpu_trace_buffer.sv
// Trace buffer that snoops SCPU bus activity on committed instructions and
// stores filtered events with a cycle timestamp in a drainable FIFO.
module scpu_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TS_W  = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic [AW-1:0]   PC_out,
  input  logic [AW-1:0]   Addr_out,
  input  logic [DW-1:0]   Data_out,
  input  logic            MemRW,
  input  logic            CPU_MIO,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   match_addr,
  input  logic            wrap_en,
  input  logic            arm,
  input  logic            stop,
  input  logic            rd_en,
  output logic            rd_valid,
  output logic [AW-1:0]   rd_pc,
  output logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_memrw,
  output logic [TS_W-1:0] rd_ts,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic [1:0]      state
);

  typedef struct packed {
    logic [AW-1:0]   pc;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic            memrw;
    logic [TS_W-1:0] ts;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_nxt;
  logic [TS_W-1:0] ts_q;
  logic            ovf_q;
  entry_t          mem [DEPTH];
  entry_t          wr_e, head_e;

  logic hit, capturing, full_now;
  logic wr_req, do_wr, do_pop, overwrite, drop;

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'b00:   hit = 1'b1;
      2'b01:   hit = CPU_MIO;
      2'b10:   hit = MemRW;
      default: hit = (Addr_out == match_addr);
    endcase
  end

  assign capturing = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign full_now  = (count_q == CW'(DEPTH));

  // arm wins over everything else sampled in the same cycle
  assign wr_req    = commit & hit & capturing & ~arm;
  assign do_pop    = rd_en & (count_q != '0) & ~arm;
  // a pop in the same cycle frees a slot, so a full buffer can still accept
  assign do_wr     = wr_req & (~full_now | wrap_en | do_pop);
  assign overwrite = do_wr & full_now & ~do_pop;
  assign drop      = wr_req & ~do_wr;
  assign count_nxt = count_q + CW'(do_wr & ~overwrite) - CW'(do_pop);

  assign wr_e = '{pc: PC_out, addr: Addr_out, data: Data_out, memrw: MemRW, ts: ts_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
    end else if (arm) begin
      state_q <= S_ARMED;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (capturing) ts_q <= ts_q + TS_W'(1);
      if (do_wr)     tail_q <= tail_q + PW'(1);
      if (do_pop | overwrite) head_q <= head_q + PW'(1);
      count_q <= count_nxt;
      if (overwrite | drop) ovf_q <= 1'b1;

      if (capturing) begin
        if (stop | drop)
          state_q <= S_DONE;
        else if (do_wr & ~wrap_en & (count_nxt == CW'(DEPTH)))
          state_q <= S_DONE;
        else if (do_wr)
          state_q <= S_CAPTURE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail_q] <= wr_e;
  end

  // first-word-fall-through head; zeroed while empty so idle outputs are clean
  assign head_e   = (count_q != '0) ? mem[head_q] : '0;
  assign rd_valid = (count_q != '0);
  assign rd_pc    = head_e.pc;
  assign rd_addr  = head_e.addr;
  assign rd_data  = head_e.data;
  assign rd_memrw = head_e.memrw;
  assign rd_ts    = head_e.ts;
  assign count    = count_q;
  assign full     = full_now;
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_scpu_trace_buffer.sv
// Scoreboard bench for scpu_trace_buffer: stimulus pushes expected entries,
// a negedge monitor compares every popped head entry.
module tb_scpu_trace_buffer;
  localparam int DEPTH = 16, AW = 32, DW = 32, TS_W = 16, CW = 5;

  logic            clk, rst, commit, MemRW, CPU_MIO, wrap_en, arm, stop, rd_en;
  logic [AW-1:0]   PC_out, Addr_out, match_addr;
  logic [DW-1:0]   Data_out;
  logic [1:0]      mode;
  logic            rd_valid, rd_memrw, full, empty, overflow;
  logic [AW-1:0]   rd_pc, rd_addr;
  logic [DW-1:0]   rd_data;
  logic [TS_W-1:0] rd_ts;
  logic [CW-1:0]   count;
  logic [1:0]      state;

  scpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .commit(commit), .PC_out(PC_out), .Addr_out(Addr_out),
    .Data_out(Data_out), .MemRW(MemRW), .CPU_MIO(CPU_MIO), .mode(mode),
    .match_addr(match_addr), .wrap_en(wrap_en), .arm(arm), .stop(stop), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_memrw(rd_memrw), .rd_ts(rd_ts), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .state(state)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        memrw;
    logic [15:0] ts;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // monitor: every accepted pop must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && rd_en && rd_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got pc 0x%0h, expected no entry", rd_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_entry", {15'b0, rd_pc, rd_addr, rd_data, rd_memrw, rd_ts}, {15'b0, mon_e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic c, input logic [31:0] pc, input logic [31:0] addr,
                    input logic [31:0] data, input logic rw, input logic mio);
    commit = c; PC_out = pc; Addr_out = addr; Data_out = data; MemRW = rw; CPU_MIO = mio;
    cyc();
    commit = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] addr,
                      input logic [31:0] data, input logic rw, input logic [15:0] ts);
    exp_t e;
    e.pc = pc; e.addr = addr; e.data = data; e.memrw = rw; e.ts = ts;
    sb.push_back(e);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) cyc();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; commit = 0; PC_out = 0; Addr_out = 0; Data_out = 0; MemRW = 0; CPU_MIO = 0;
    mode = 2'b00; match_addr = 0; wrap_en = 0; arm = 0; stop = 0; rd_en = 0;
    #3;
    chk("rst_state", 128'(state), 128'(2'b00));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_flags", {125'b0, empty, full, overflow}, {125'b0, 3'b100});
    chk("rst_rd", {15'b0, rd_valid, rd_pc, rd_addr, rd_data, rd_ts}, 128'(0));
    #9 rst = 1'b0;
    cyc();

    // mode 00: three commits, timestamps 0,1,2
    mode = 2'b00;
    do_arm();
    chk("arm_state", 128'(state), 128'(2'b01));
    for (int i = 0; i < 3; i++) begin
      ev(1, 32'(4*i), 32'h1000 + 32'(4*i), 32'hD000 + 32'(i), 0, 0);
      push(32'(4*i), 32'h1000 + 32'(4*i), 32'hD000 + 32'(i), 0, 16'(i));
    end
    chk("m00_count", 128'(count), 128'(3));
    chk("m00_state", 128'(state), 128'(2'b10));
    drain(3);
    chk("m00_empty", 128'(empty), 128'(1));
    chk("m00_sb", 128'(sb.size()), 128'(0));

    // mode 10: only stores captured
    mode = 2'b10;
    do_arm();
    ev(1, 32'h10, 32'h00, 32'h0,    0, 0);
    ev(1, 32'h14, 32'h08, 32'hAAAA, 1, 1); push(32'h14, 32'h08, 32'hAAAA, 1, 16'd1);
    ev(1, 32'h18, 32'h10, 32'h0,    0, 1);
    ev(1, 32'h1C, 32'h0C, 32'hBBBB, 1, 1); push(32'h1C, 32'h0C, 32'hBBBB, 1, 16'd3);
    chk("m10_count", 128'(count), 128'(2));
    drain(2);
    chk("m10_sb", 128'(sb.size()), 128'(0));

    // mode 11: address match trigger
    mode = 2'b11; match_addr = 32'h0C;
    do_arm();
    ev(1, 32'h20, 32'h04, 32'h1, 0, 1);
    chk("m11_armed0", 128'(state), 128'(2'b01));
    ev(1, 32'h24, 32'h08, 32'h2, 0, 1);
    chk("m11_armed1", 128'(state), 128'(2'b01));
    ev(1, 32'h28, 32'h0C, 32'h3, 1, 1); push(32'h28, 32'h0C, 32'h3, 1, 16'd2);
    chk("m11_capture", 128'(state), 128'(2'b10));
    ev(1, 32'h2C, 32'h0C, 32'h4, 0, 1); push(32'h2C, 32'h0C, 32'h4, 0, 16'd3);
    chk("m11_count", 128'(count), 128'(2));
    drain(2);

    // stop-on-full: 20 commits, first 16 kept
    mode = 2'b00; wrap_en = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      ev(1, 32'h100 + 32'(4*i), 32'h2000 + 32'(i), 32'(i), 0, 0);
      if (i < 16) push(32'h100 + 32'(4*i), 32'h2000 + 32'(i), 32'(i), 0, 16'(i));
      if (i == 15) chk("nowrap_done16", 128'(state), 128'(2'b11));
    end
    chk("nowrap_count", 128'(count), 128'(16));
    chk("nowrap_flags", {126'b0, full, overflow}, {126'b0, 2'b10});
    chk("nowrap_head", 128'(rd_pc), 128'(32'h100));
    drain(16);
    chk("nowrap_sb", 128'(sb.size()), 128'(0));

    // ring mode: 20 commits, head is 5th event
    wrap_en = 1'b1;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      ev(1, 32'h200 + 32'(4*i), 32'h3000 + 32'(i), 32'(i), 1, 0);
      if (i >= 4) push(32'h200 + 32'(4*i), 32'h3000 + 32'(i), 32'(i), 1, 16'(i));
    end
    chk("wrap_count", 128'(count), 128'(16));
    chk("wrap_ovf", 128'(overflow), 128'(1));
    chk("wrap_state", 128'(state), 128'(2'b10));
    chk("wrap_head", 128'(rd_pc), 128'(32'h210));
    drain(16);

    // full ring with pops alongside writes: no overwrite
    do_arm();
    for (int i = 0; i < 20; i++) begin
      if (i == 16) rd_en = 1'b1;
      ev(1, 32'h300 + 32'(4*i), 32'h4000 + 32'(i), 32'(i), 0, 0);
      push(32'h300 + 32'(4*i), 32'h4000 + 32'(i), 32'(i), 0, 16'(i));
    end
    rd_en = 1'b0;
    chk("popwr_count", 128'(count), 128'(16));
    chk("popwr_ovf", 128'(overflow), 128'(0));
    drain(16);
    chk("popwr_sb", 128'(sb.size()), 128'(0));

    // arm + stop together re-arms; stop with commit still writes
    wrap_en = 1'b0;
    do_arm();
    ev(1, 32'h400, 32'h0, 32'h0, 0, 0);
    ev(1, 32'h404, 32'h0, 32'h0, 0, 0);
    arm = 1'b1; stop = 1'b1;
    ev(1, 32'h408, 32'h0, 32'h0, 0, 0);
    arm = 1'b0; stop = 1'b0;
    chk("armstop_state", 128'(state), 128'(2'b01));
    chk("armstop_count", 128'(count), 128'(0));
    stop = 1'b1;
    ev(1, 32'h40C, 32'h5, 32'h6, 1, 1); push(32'h40C, 32'h5, 32'h6, 1, 16'd0);
    stop = 1'b0;
    chk("stop_state", 128'(state), 128'(2'b11));
    ev(1, 32'h410, 32'h0, 32'h0, 0, 0);
    chk("stop_count", 128'(count), 128'(1));
    drain(1);

    // async reset mid-capture
    wrap_en = 1'b1;
    do_arm();
    for (int i = 0; i < 17; i++) ev(1, 32'h500 + 32'(4*i), 32'h0, 32'(i), 0, 0);
    chk("pre_rst_ovf", 128'(overflow), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 128'(state), 128'(2'b00));
    chk("arst_flags", {124'b0, count != 0, empty, full, overflow}, {124'b0, 4'b0100});
    chk("arst_rd", {15'b0, rd_valid, rd_pc, rd_addr, rd_data, rd_ts}, 128'(0));
    #1 rst = 1'b0;
    cyc();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("empty_pop", {126'b0, count != 0, empty}, {126'b0, 2'b01});
    chk("final_sb", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scpu_trace_buffer.md
# scpu_trace_buffer

Parametrised, synthesizable successor to the SCPU bench stimulus/print flow. It sits beside `SCPU` and snoops its bus outputs (`PC_out`, `Addr_out`, `Data_out`, `MemRW`, `CPU_MIO`) on every committed instruction. Qualifying events are filtered by a selectable trigger mode and stored with a cycle timestamp in a FIFO buffer, which a debug port drains. Wrap (ring) and stop-on-full modes are supported.

## Interface
- `DEPTH`, 16, number of trace entries; power of 2, ≥2
- `AW`, 32, width of PC/address fields
- `DW`, 32, width of data field
- `TS_W`, 16, timestamp width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `commit`  in  1  SCPU retired an instruction this cycle (tie to `MIO_ready` in the single-cycle build)
- `PC_out`  in  AW  snooped PC
- `Addr_out`  in  AW  snooped bus address
- `Data_out`  in  DW  snooped store data
- `MemRW`  in  1  snooped write strobe (1 = store)
- `CPU_MIO`  in  1  snooped memory/IO access flag
- `mode`  in  2  00 all commits; 01 `CPU_MIO`=1; 10 `MemRW`=1; 11 `Addr_out`==`match_addr`
- `match_addr`  in  AW  compare value for mode 11
- `wrap_en`  in  1  1 = ring (overwrite oldest), 0 = stop when full
- `arm`  in  1  single-cycle pulse: clear buffer and timestamp, enter ARMED
- `stop`  in  1  single-cycle pulse: force DONE
- `rd_en`  in  1  pop head entry
- `rd_valid`  out  1  head entry valid (= !empty)
- `rd_pc`, `rd_addr`  out  AW  head entry fields
- `rd_data`  out  DW  head entry field
- `rd_memrw`  out  1  head entry field
- `rd_ts`  out  TS_W  head entry timestamp
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `full`, `empty`  out  1  occupancy flags
- `overflow`  out  1  sticky: an entry was dropped or overwritten
- `state`  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE

## Operation
- Qualify `q = commit & match(mode)`; timestamp counter `ts` increments every cycle in ARMED/CAPTURE, wraps modulo 2^TS_W, holds in IDLE/DONE.
- IDLE: no capture. `arm` → ARMED.
- ARMED: first `q` is written (trigger entry) → CAPTURE.
- CAPTURE: each `q` writes {PC, Addr, Data, MemRW, ts} at tail.
  - Full, `wrap_en`=0: the write that makes count=DEPTH moves state to DONE; no further writes.
  - Full, `wrap_en`=1: overwrite oldest, advance head, count stays DEPTH, set `overflow`.
- DONE: no capture. `arm` → ARMED.
- `stop` in ARMED/CAPTURE → DONE; a `q` in the same cycle is still written.
- `arm` in any state: pointers, count, `overflow`, `ts` cleared; same-cycle `q`, `rd_en`, `stop` ignored; `arm` beats `stop`.
- Read: first-word-fall-through; `rd_*` show the head combinationally when `rd_valid`. `rd_en` pops on the edge; `rd_en` while empty is ignored.
- Simultaneous write and pop: both occur, count unchanged. When full with wrap, pop + write causes no overwrite and no `overflow`.
- Reads are allowed in every state, including during capture.

## Timing
- Reset (async): state=IDLE, count=0, `empty`=1, `full`=0, `overflow`=0, `rd_valid`=0, all `rd_*`=0, `ts`=0, pointers=0.
- Write latency: entry captured on edge N is visible at `rd_*`/`count` after edge N (one cycle).
- State transitions take effect on the edge where the cause is sampled.
- Pointers wrap modulo DEPTH; count saturates at DEPTH.
- `rst` asserted mid-capture clears everything immediately; in-flight data is lost.

## Test plan
- Reset, `arm`, mode 00, 3 commits with PC 0x0/0x4/0x8 → count=3; pops return PC 0,4,8 with increasing `rd_ts`; `empty`=1 after the third pop.
- Mode 10, stream ADD/SW/LW/SW (MemRW 0,1,0,1), store `Addr_out` 0x08/0x0C → exactly 2 entries, addr 0x08 then 0x0C.
- Mode 11 with `match_addr`=0x0C over addrs 0x04,0x08,0x0C,0x0C → state ARMED until the first 0x0C, then CAPTURE; count=2.
- DEPTH=16, `wrap_en`=0, 20 commits → state DONE after the 16th, count=16, `overflow`=0, head PC = first PC. With `wrap_en`=1 → count=16, `overflow`=1, head = 5th event.
- Full with wrap, `rd_en` held during 4 commits → count stays 16, `overflow` stays 0.
- `arm` and `stop` in the same cycle during CAPTURE → state ARMED, count=0. `rst` pulse mid-capture → all outputs return to reset values asynchronously.
